// File: rtl/rv32i_mem_top.sv
// RV32I memory stage: drives the data-RAM request, registers the payload for writeback, formats load data.
// Optional feature MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on misalign_out.
module rv32i_mem_top #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] iw_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      wb_reg_in,
  input  logic            wb_en_in,
  input  logic [1:0]      src_sel_in,
  output logic [XLEN-1:0] memif_addr,
  output logic            memif_we,
  output logic [3:0]      memif_be,
  output logic [XLEN-1:0] memif_wdata,
  input  logic [XLEN-1:0] memif_rdata_raw,
  output logic [XLEN-1:0] memif_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] iw_out,
  output logic [XLEN-1:0] alu_out,
  output logic [4:0]      wb_reg_out,
  output logic            wb_en_out,
  output logic [1:0]      src_sel_out,
  output logic            misalign_out,
  output logic            df_mem_enable,
  output logic [4:0]      df_mem_reg,
  output logic [XLEN-1:0] df_mem_data
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic       is_load;
  logic       is_store;
  logic [2:0] f3;
  logic [1:0] a;
  logic       misaligned;

  logic [XLEN-1:0] pc_d, pc_q, iw_d, iw_q, alu_d, alu_q;
  logic [4:0]      wb_reg_d, wb_reg_q;
  logic            wb_en_d, wb_en_q;
  logic [1:0]      src_sel_d, src_sel_q;
  logic            misalign_d, misalign_q;
  logic [2:0]      ld_f3_d, ld_f3_q;
  logic [1:0]      ld_a_d, ld_a_q;
  logic            ld_v_d, ld_v_q;

  assign f3       = iw_in[14:12];
  assign a        = alu_in[1:0];
  assign is_load  = (iw_in[6:0] == OP_LOAD);
  assign is_store = (iw_in[6:0] == OP_STORE);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_load | is_store) &
                      (((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00)));
`else
  // Without the trap, halves and words simply ignore the low address bits.
  assign misaligned = 1'b0;
`endif

  always_comb begin
    memif_addr  = {alu_in[XLEN-1:2], 2'b00};
    memif_be    = 4'b0000;
    memif_wdata = rs2_in;
    memif_we    = 1'b0;
    if (is_store) begin
      case (f3[1:0])
        2'b00: begin
          memif_be    = 4'b0001 << a;
          memif_wdata = {4{rs2_in[7:0]}};
        end
        2'b01: begin
          memif_be    = a[1] ? 4'b1100 : 4'b0011;
          memif_wdata = {2{rs2_in[15:0]}};
        end
        2'b10: begin
          memif_be    = 4'b1111;
          memif_wdata = rs2_in;
        end
        default: memif_be = 4'b0000;
      endcase
      memif_we = (f3[1:0] != 2'b11) & ~reset & ~misaligned;
    end
  end

  always_comb begin
    pc_d       = pc_in;
    iw_d       = iw_in;
    alu_d      = alu_in;
    wb_reg_d   = wb_reg_in;
    src_sel_d  = src_sel_in;
    wb_en_d    = wb_en_in & ~(is_load & misaligned);
    misalign_d = misaligned;
    ld_f3_d    = f3;
    ld_a_d     = a;
    ld_v_d     = is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      iw_q       <= '0;
      alu_q      <= '0;
      wb_reg_q   <= '0;
      wb_en_q    <= 1'b0;
      src_sel_q  <= '0;
      misalign_q <= 1'b0;
      ld_f3_q    <= '0;
      ld_a_q     <= '0;
      ld_v_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      iw_q       <= iw_d;
      alu_q      <= alu_d;
      wb_reg_q   <= wb_reg_d;
      wb_en_q    <= wb_en_d;
      src_sel_q  <= src_sel_d;
      misalign_q <= misalign_d;
      ld_f3_q    <= ld_f3_d;
      ld_a_q     <= ld_a_d;
      ld_v_q     <= ld_v_d;
    end
  end

  // Load formatting runs on the registered request and the RAM word returned this cycle.
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    case (ld_a_q)
      2'd0:    byte_val = memif_rdata_raw[7:0];
      2'd1:    byte_val = memif_rdata_raw[15:8];
      2'd2:    byte_val = memif_rdata_raw[23:16];
      default: byte_val = memif_rdata_raw[31:24];
    endcase
    half_val    = ld_a_q[1] ? memif_rdata_raw[31:16] : memif_rdata_raw[15:0];
    memif_rdata = '0;
    if (ld_v_q) begin
      case (ld_f3_q)
        3'b000:  memif_rdata = {{(XLEN-8){byte_val[7]}}, byte_val};
        3'b100:  memif_rdata = {{(XLEN-8){1'b0}}, byte_val};
        3'b001:  memif_rdata = {{(XLEN-16){half_val[15]}}, half_val};
        3'b101:  memif_rdata = {{(XLEN-16){1'b0}}, half_val};
        3'b010:  memif_rdata = memif_rdata_raw;
        default: memif_rdata = '0;
      endcase
    end
  end

  assign pc_out        = pc_q;
  assign iw_out        = iw_q;
  assign alu_out       = alu_q;
  assign wb_reg_out    = wb_reg_q;
  assign wb_en_out     = wb_en_q;
  assign src_sel_out   = src_sel_q;
  assign misalign_out  = misalign_q;
  assign df_mem_enable = wb_en_q;
  assign df_mem_reg    = wb_reg_q;
  assign df_mem_data   = alu_q;

endmodule

// File: tb/tb_rv32i_mem_top.sv
// Testbench for rv32i_mem_top: vector table with a scoreboard queue for the registered stage,
// plus hand-written reset and store-then-load sequences against a small behavioural RAM.
module tb_rv32i_mem_top;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, iw_in, alu_in, rs2_in;
  logic [4:0]  wb_reg_in;
  logic        wb_en_in;
  logic [1:0]  src_sel_in;
  logic [31:0] memif_addr, memif_wdata, memif_rdata_raw, memif_rdata;
  logic        memif_we;
  logic [3:0]  memif_be;
  logic [31:0] pc_out, iw_out, alu_out, df_mem_data;
  logic [4:0]  wb_reg_out, df_mem_reg;
  logic        wb_en_out, misalign_out, df_mem_enable;
  logic [1:0]  src_sel_out;

  int checks = 0;
  int failures = 0;

  rv32i_mem_top #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
    .rs2_in(rs2_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .src_sel_in(src_sel_in),
    .memif_addr(memif_addr), .memif_we(memif_we), .memif_be(memif_be),
    .memif_wdata(memif_wdata), .memif_rdata_raw(memif_rdata_raw), .memif_rdata(memif_rdata),
    .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out), .wb_reg_out(wb_reg_out),
    .wb_en_out(wb_en_out), .src_sel_out(src_sel_out), .misalign_out(misalign_out),
    .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with byte enables and a registered read port.
  logic [31:0] ram [0:1023];
  logic [31:0] ram_rd;
  initial for (int k = 0; k < 1024; k++) ram[k] = 32'h0;
  always @(posedge clk) begin
    if (memif_we)
      for (int b = 0; b < 4; b++)
        if (memif_be[b]) ram[memif_addr[11:2]][8*b +: 8] <= memif_wdata[8*b +: 8];
    ram_rd <= ram[memif_addr[11:2]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, raw;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_rdata;
    logic        e_wb_en, e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc, iw, alu, rdata, raw;
    logic [4:0]  wb_reg;
    logic        wb_en, mis;
    logic [1:0]  src_sel;
  } exp_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  exp_t sb [$];

  function automatic logic [31:0] mkIw(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [31:0] raw, input logic [4:0] wb_reg,
                               input logic wb_en, input logic [3:0] e_be, input logic e_we,
                               input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                               input logic e_wb_en, input logic e_mis);
    vec_t v;
    v.op = op; v.f3 = f3; v.alu = alu; v.rs2 = rs2; v.raw = raw;
    v.wb_reg = wb_reg; v.wb_en = wb_en; v.e_be = e_be; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_wb_en = e_wb_en; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [4:0] wb_reg, input logic wb_en,
                               input logic [1:0] src_sel);
    iw_in      = mkIw(f3, op);
    pc_in      = pc;
    alu_in     = alu;
    rs2_in     = rs2;
    wb_reg_in  = wb_reg;
    wb_en_in   = wb_en;
    src_sel_in = src_sel;
  endtask

  task automatic checkRegs(input exp_t e);
    checkOutput("pc_out", pc_out, e.pc);
    checkOutput("iw_out", iw_out, e.iw);
    checkOutput("alu_out", alu_out, e.alu);
    checkOutput("wb_reg_out", {27'd0, wb_reg_out}, {27'd0, e.wb_reg});
    checkOutput("wb_en_out", {31'd0, wb_en_out}, {31'd0, e.wb_en});
    checkOutput("src_sel_out", {30'd0, src_sel_out}, {30'd0, e.src_sel});
    checkOutput("misalign_out", {31'd0, misalign_out}, {31'd0, e.mis});
    checkOutput("memif_rdata", memif_rdata, e.rdata);
    checkOutput("df_mem_enable", {31'd0, df_mem_enable}, {31'd0, e.wb_en});
    checkOutput("df_mem_reg", {27'd0, df_mem_reg}, {27'd0, e.wb_reg});
    checkOutput("df_mem_data", df_mem_data, e.alu);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  exp_t e, ne;
  bit   have;

  initial begin
    tbl[0]  = mkv(OP_STORE, 3'b000, 32'h104, 32'h000000AB, 32'h0, 5'd0, 1'b0, 4'b0001, 1'b1, 32'hABABABAB, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mkv(OP_STORE, 3'b001, 32'h106, 32'h00001234, 32'h0, 5'd0, 1'b0, 4'b1100, 1'b1, 32'h12341234, 32'h0, 1'b0, 1'b0);
    tbl[2]  = mkv(OP_STORE, 3'b010, 32'h108, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    tbl[3]  = mkv(OP_LOAD,  3'b000, 32'h203, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0);
    tbl[4]  = mkv(OP_LOAD,  3'b100, 32'h203, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h00000080, 1'b1, 1'b0);
    tbl[5]  = mkv(OP_LOAD,  3'b001, 32'h202, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'hFFFF80FF, 1'b1, 1'b0);
    tbl[6]  = mkv(OP_LOAD,  3'b101, 32'h200, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h00007F01, 1'b1, 1'b0);
    tbl[7]  = mkv(OP_LOAD,  3'b010, 32'h300, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h80FF7F01, 1'b1, 1'b0);
    tbl[8]  = mkv(OP_LOAD,  3'b000, 32'h201, 32'h0, 32'h80FF7F01, 5'd3, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0000007F, 1'b1, 1'b0);
    tbl[9]  = mkv(OP_ALU,   3'b000, 32'h55,  32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[10] = mkv(OP_STORE, 3'b011, 32'h10C, 32'h77, 32'h0, 5'd0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[11] = mkv(OP_STORE, 3'b000, 32'h10A, 32'h5A, 32'h0, 5'd0, 1'b0, 4'b0100, 1'b1, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
    tbl[12] = mkv(OP_STORE, 3'b010, 32'h102, 32'h01020304, 32'h0, 5'd0, 1'b0, 4'b1111, !TRAP, 32'h01020304, 32'h0, 1'b0, TRAP);
    tbl[13] = mkv(OP_LOAD,  3'b010, 32'h101, 32'h0, 32'h80FF7F01, 5'd4, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h80FF7F01, !TRAP, TRAP);
    tbl[14] = mkv(OP_LOAD,  3'b001, 32'h201, 32'h0, 32'h80FF7F01, 5'd6, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h00007F01, !TRAP, TRAP);
    tbl[15] = mkv(OP_ALU,   3'b000, 32'h99,  32'h0, 32'h0, 5'd8, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset with a store presented: no write, all registered outputs clear, load valid cleared.
    reset = 1'b1;
    memif_rdata_raw = 32'hFFFFFFFF;
    applyStimulus(OP_STORE, 3'b010, 32'h40, 32'h600, 32'h11111111, 5'd9, 1'b1, 2'd3);
    #1;
    checkOutput("reset_we", {31'd0, memif_we}, 32'd0);
    nextCycle();
    applyStimulus(OP_LOAD, 3'b010, 32'h44, 32'h600, 32'h0, 5'd9, 1'b1, 2'd3);
    nextCycle();
    e = '{pc: 0, iw: 0, alu: 0, rdata: 0, raw: 0, wb_reg: 0, wb_en: 0, mis: 0, src_sel: 0};
    checkRegs(e);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i].op, tbl[i].f3, 32'h1000 + 32'(4 * i), tbl[i].alu, tbl[i].rs2,
                    tbl[i].wb_reg, tbl[i].wb_en, 2'(i));
      have = (sb.size() > 0);
      if (have) begin
        e = sb.pop_front();
        memif_rdata_raw = e.raw;
      end
      #2;
      checkOutput($sformatf("addr[%0d]", i), memif_addr, {tbl[i].alu[31:2], 2'b00});
      checkOutput($sformatf("we[%0d]", i), {31'd0, memif_we}, {31'd0, tbl[i].e_we});
      checkOutput($sformatf("be[%0d]", i), {28'd0, memif_be}, {28'd0, tbl[i].e_be});
      if (tbl[i].e_be != 4'b0000)
        checkOutput($sformatf("wdata[%0d]", i), memif_wdata, tbl[i].e_wdata);
      if (have) checkRegs(e);
      ne.pc = 32'h1000 + 32'(4 * i);
      ne.iw = mkIw(tbl[i].f3, tbl[i].op);
      ne.alu = tbl[i].alu;
      ne.rdata = tbl[i].e_rdata;
      ne.raw = tbl[i].raw;
      ne.wb_reg = tbl[i].wb_reg;
      ne.wb_en = tbl[i].e_wb_en;
      ne.mis = tbl[i].e_mis;
      ne.src_sel = 2'(i);
      sb.push_back(ne);
      nextCycle();
    end
    applyStimulus(OP_ALU, 3'b000, 32'h2000, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      memif_rdata_raw = e.raw;
      #2;
      checkRegs(e);
    end else begin
      checkOutput("scoreboard_depth", 32'(sb.size()), 32'd1);
    end
    nextCycle();

    // Store then load to the same word: the load must see the freshly written data.
    applyStimulus(OP_STORE, 3'b010, 32'h3000, 32'h400, 32'hCAFEF00D, 5'd0, 1'b0, 2'd0);
    #1;
    checkOutput("rw_store_we", {31'd0, memif_we}, 32'd1);
    nextCycle();
    applyStimulus(OP_LOAD, 3'b010, 32'h3004, 32'h400, 32'h0, 5'd7, 1'b1, 2'd1);
    memif_rdata_raw = ram_rd;
    nextCycle();
    applyStimulus(OP_LOAD, 3'b001, 32'h3008, 32'h402, 32'h0, 5'd7, 1'b1, 2'd1);
    memif_rdata_raw = ram_rd;
    #1;
    checkOutput("rw_lw", memif_rdata, 32'hCAFEF00D);
    nextCycle();
    applyStimulus(OP_LOAD, 3'b010, 32'h300C, 32'h600, 32'h0, 5'd9, 1'b1, 2'd2);
    memif_rdata_raw = ram_rd;
    #1;
    checkOutput("rw_lh", memif_rdata, 32'hFFFFCAFE);
    nextCycle();
    // The store presented during reset must have left this word untouched.
    applyStimulus(OP_ALU, 3'b000, 32'h3010, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
    memif_rdata_raw = ram_rd;
    #1;
    checkOutput("reset_no_write", memif_rdata, 32'h0);
    checkOutput("reset_load_wb_en", {31'd0, wb_en_out}, 32'd1);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_top.md
Name: rv32i_mem_top

Overview:
- Memory stage of the RV32I pipeline. Sits between the execute stage (upstream) and the writeback stage (downstream).
- Decodes load/store from the instruction word and drives the synchronous data-RAM port with word address, byte enables and lane-replicated store data.
- Registers the pipeline payload for writeback.
- Formats the raw RAM read word (lane select, sign/zero extension) in the following cycle, so writeback receives a ready memif_rdata.
- Provides mem-stage forwarding outputs to decode.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc_in  in  32  PC from execute
- iw_in  in  32  instruction word from execute
- alu_in  in  32  ALU result; effective address for loads/stores
- rs2_in  in  32  store data from execute
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  writeback enable
- src_sel_in  in  2  writeback source select; passed through unchanged
- memif_addr  out  32  word-aligned RAM address
- memif_we  out  1  RAM write strobe
- memif_be  out  4  byte enables
- memif_wdata  out  32  store data, lane-replicated
- memif_rdata_raw  in  32  RAM read word, valid the cycle after the address
- memif_rdata  out  32  formatted load data to writeback
- pc_out, iw_out, alu_out  out  32 each  registered payload to writeback
- wb_reg_out  out  5  registered destination register
- wb_en_out  out  1  registered writeback enable
- src_sel_out  out  2  registered source select
- misalign_out  out  1  misaligned-access flag, registered
- df_mem_enable  out  1  forwarding: equals wb_en_out
- df_mem_reg  out  5  forwarding: equals wb_reg_out
- df_mem_data  out  32  forwarding: equals alu_out

Behaviour:
- Decode (combinational, from iw_in):
  - load = iw_in[6:0]==7'b0000011; store = iw_in[6:0]==7'b0100011.
  - f3 = iw_in[14:12]; a = alu_in[1:0].
- RAM request (combinational, same cycle as inputs):
  - memif_addr = {alu_in[31:2],2'b00}, driven for every instruction.
  - memif_we = store & ~reset (& ~misaligned when the feature is enabled).
- Store lanes, f3[1:0]:
  - 00 SB: be = 4'b0001<<a; wdata = {4{rs2_in[7:0]}}.
  - 01 SH: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2_in[15:0]}}.
  - 10 SW: be = 4'b1111; wdata = rs2_in.
  - 11: be = 0, we = 0.
- Non-store: memif_be = 0; memif_wdata = rs2_in (don't-care).
- Pipeline registers (posedge clk):
  - pc, iw, alu, wb_reg and src_sel register their inputs.
  - wb_en_out <= wb_en_in.
  - Registered internally: ld_f3 <= f3; ld_a <= a; ld_v <= load.
  - Latency 1 cycle, no stalls; a new instruction is accepted every cycle.
- Reset (synchronous):
  - All registered outputs become 0, including wb_en_out, misalign_out and ld_v.
  - memif_we is forced 0 while reset is high.
  - Reset mid-stream discards the in-flight instruction; no RAM write occurs in that cycle.
- Load formatting (combinational, cycle after request, uses ld_* registers and memif_rdata_raw):
  - Byte value = raw[8*ld_a +: 8].
  - Half value = ld_a[1] ? raw[31:16] : raw[15:0].
  - f3 000 LB: sign-extended byte.
  - f3 100 LBU: zero-extended byte.
  - f3 001 LH: sign-extended half.
  - f3 101 LHU: zero-extended half.
  - f3 010 LW: raw.
  - Other f3: 0.
  - ld_v==0: memif_rdata = 0.
- Forwarding:
  - df_mem_data carries alu_out, never load data.
  - Load-use hazards are resolved by a decode stall.
- Back-to-back store then load to the same word: the RAM's read-during-write behaviour applies. The required result is that the load returns the new data, because the write commits on the request edge and the read is issued one cycle later.
- Misaligned definition: LH/LHU/SH with a[0]=1, or LW/SW with a!=0.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store forces memif_we=0.
  - A misaligned load registers wb_en_out=0.
  - misalign_out <= 1 for exactly one cycle, aligned with the registered instruction.
  - alu_out still carries the faulting address.
- Undefined:
  - misalign_out is tied to 0.
  - Accesses proceed with the low address bits truncated per the lane rules above: SH/LH ignore a[0]; SW/LW ignore a.

Test Plan:
- SB: alu_in=0x104, rs2_in=0x000000AB -> memif_addr=0x104, be=0001, wdata=0xABABABAB, we=1.
- SH: alu_in=0x106, rs2=0x1234 -> be=1100, wdata=0x12341234; SW at 0x108 -> be=1111.
- Load formatting with raw=0x80FF7F01:
  - LB a=3 -> 0xFFFFFF80.
  - LBU a=3 -> 0x00000080.
  - LH a=2 -> 0xFFFF80FF.
  - LHU a=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Payload: ADD with wb_en_in=1, wb_reg_in=5, alu_in=0x55 -> next cycle wb_en_out=1, df_mem_reg=5, df_mem_data=0x55, memif_we=0, memif_rdata=0.
- Reset asserted in the same cycle as an SW -> memif_we=0; next cycle all outputs 0 and wb_en_out=0.
- Misaligned access:
  - MISALIGN_TRAP_EN defined: SW at 0x102 -> we=0, misalign_out=1 for one cycle; LW at 0x101 with wb_en_in=1 -> wb_en_out=0, misalign_out=1.
  - Macro undefined: SW at 0x102 -> we=1, be=1111, addr=0x100.
